// File: rtl/io_n_bidir_filter.sv
// rtl/io_n_bidir_filter.sv - N-channel bidirectional pad IO with input synchroniser and debounce filter
// Optional feature macro: IO_DEBOUNCE_EN (counter-based debounce; when undefined the filter is a 1-cycle register)
module io_n_bidir_filter #(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CNT  = 4
) (
  input  logic                UserCLK,
  input  logic                Reset,
  input  logic [NUM_CH-1:0]   I,
  input  logic [NUM_CH-1:0]   T,
  output logic [NUM_CH-1:0]   O,
  output logic [NUM_CH-1:0]   Q,
  output logic [NUM_CH-1:0]   ChangeEvt,
  input  logic [NUM_CH-1:0]   O_top,
  output logic [NUM_CH-1:0]   I_top,
  output logic [NUM_CH-1:0]   T_top,
  input  logic [4*NUM_CH-1:0] ConfigBits
);

  // Reject illegal parameterisations at elaboration time
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("io_n_bidir_filter: NUM_CH must be 1..16");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("io_n_bidir_filter: SYNC_STAGES must be 1..4");
  end
  if (FILTER_CNT < 1 || FILTER_CNT > 255) begin : g_bad_filter_cnt
    $error("io_n_bidir_filter: FILTER_CNT must be 1..255");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Per-channel configuration: OREG, TINV, SYNC, EDGE_EN from bit 0 upward
    logic oreg;
    logic tinv;
    logic sync_sel;
    logic edge_en;
    logic [SYNC_STAGES-1:0] sync_chain;
    logic s;
    logic filt;
    logic accept;
    logic q_reg;
    logic evt_reg;
    logic i_reg;
    logic t_reg;

    assign oreg     = ConfigBits[4*c+0];
    assign tinv     = ConfigBits[4*c+1];
    assign sync_sel = ConfigBits[4*c+2];
    assign edge_en  = ConfigBits[4*c+3];

    // Synchroniser shifts every cycle even when bypassed, so toggling SYNC finds fresh history
    always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
        sync_chain <= '0;
      end else begin
        sync_chain[0] <= O_top[c];
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_chain[k] <= sync_chain[k-1];
        end
      end
    end

    assign s = sync_sel ? sync_chain[SYNC_STAGES-1] : O_top[c];

`ifdef IO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(FILTER_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 1);
    logic [CNT_W-1:0] cnt;

    // A change is accepted on the FILTER_CNT-th consecutive disagreeing cycle
    assign accept = (s != filt) && (cnt == CNT_LAST);

    // Count consecutive disagreeing cycles; any agreement (bounce) restarts the count from zero
    always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
        filt <= 1'b0;
        cnt  <= '0;
      end else if (s == filt) begin
        cnt <= '0;
      end else if (accept) begin
        filt <= s;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
`else
    assign accept = (s != filt);

    // Without debounce the filtered value simply follows the selected input one cycle later
    always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
        filt <= 1'b0;
      end else begin
        filt <= s;
      end
    end
`endif

    // Delayed copy and change pulse, aligned so the pulse coincides with the new value on O
    always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
        q_reg   <= 1'b0;
        evt_reg <= 1'b0;
      end else begin
        q_reg   <= filt;
        evt_reg <= accept & edge_en;
      end
    end

    // Output-side registers always track their inputs so enabling OREG shows the last sample
    always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
        i_reg <= 1'b0;
        t_reg <= 1'b1;
      end else begin
        i_reg <= I[c];
        t_reg <= T[c] ^ tinv;
      end
    end

    assign O[c]         = filt;
    assign Q[c]         = q_reg;
    assign ChangeEvt[c] = evt_reg;
    assign I_top[c]     = oreg ? i_reg : I[c];
    assign T_top[c]     = oreg ? t_reg : (T[c] ^ tinv);
  end

endmodule

// File: tb/tb_io_n_bidir_filter.sv
// tb/tb_io_n_bidir_filter.sv - self-checking bench for io_n_bidir_filter
module tb_io_n_bidir_filter;

  localparam int NUM_CH      = 2;
  localparam int SYNC_STAGES = 2;
  localparam int FILTER_CNT  = 4;
`ifdef IO_DEBOUNCE_EN
  localparam int FC_M  = FILTER_CNT;
  localparam int LAT_A = SYNC_STAGES + FILTER_CNT;
  localparam int LAT_B = 8;
  localparam int LAT_D = FILTER_CNT;
  localparam bit DEB   = 1'b1;
`else
  localparam int FC_M  = 1;
  localparam int LAT_A = SYNC_STAGES + 1;
  localparam int LAT_B = 1;
  localparam int LAT_D = 1;
  localparam bit DEB   = 1'b0;
`endif

  logic                UserCLK;
  logic                Reset;
  logic [NUM_CH-1:0]   I;
  logic [NUM_CH-1:0]   T;
  logic [NUM_CH-1:0]   O;
  logic [NUM_CH-1:0]   Q;
  logic [NUM_CH-1:0]   ChangeEvt;
  logic [NUM_CH-1:0]   O_top;
  logic [NUM_CH-1:0]   I_top;
  logic [NUM_CH-1:0]   T_top;
  logic [4*NUM_CH-1:0] ConfigBits;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  io_n_bidir_filter #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .FILTER_CNT(FILTER_CNT)
  ) dut (
    .UserCLK(UserCLK), .Reset(Reset), .I(I), .T(T), .O(O), .Q(Q),
    .ChangeEvt(ChangeEvt), .O_top(O_top), .I_top(I_top), .T_top(T_top),
    .ConfigBits(ConfigBits)
  );

  initial begin
    UserCLK = 1'b0;
    forever #5 UserCLK = ~UserCLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: delay line for the synchroniser, sliding window of filter inputs
  bit               dl [NUM_CH][$];
  bit               sh [NUM_CH][$];
  logic [NUM_CH-1:0] m_f, m_q, m_evt, m_i, m_t;

  always @(posedge UserCLK or posedge Reset) begin : model
    bit sv;
    bit acc;
    if (Reset) begin
      m_f = '0; m_q = '0; m_evt = '0; m_i = '0; m_t = '1;
      for (int c = 0; c < NUM_CH; c++) begin
        dl[c].delete();
        sh[c].delete();
        for (int k = 0; k < SYNC_STAGES; k++) dl[c].push_back(1'b0);
      end
    end else begin
      m_q = m_f;
      for (int c = 0; c < NUM_CH; c++) begin
        m_i[c] = I[c];
        m_t[c] = T[c] ^ ConfigBits[4*c+1];
        sv = ConfigBits[4*c+2] ? dl[c][0] : O_top[c];
        void'(dl[c].pop_front());
        dl[c].push_back(O_top[c]);
        sh[c].push_back(sv);
        if (sh[c].size() > FC_M) void'(sh[c].pop_front());
        acc = (sh[c].size() == FC_M);
        for (int j = 0; j < sh[c].size(); j++) if (sh[c][j] == m_f[c]) acc = 1'b0;
        m_evt[c] = acc & ConfigBits[4*c+3];
        if (acc) m_f[c] = sv;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge UserCLK) begin : compare
    logic [NUM_CH-1:0] ei, et;
    if (chk_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ei[c] = ConfigBits[4*c] ? m_i[c] : I[c];
        et[c] = ConfigBits[4*c] ? m_t[c] : (T[c] ^ ConfigBits[4*c+1]);
      end
      check("cmp_O", 32'(O), 32'(m_f));
      check("cmp_Q", 32'(Q), 32'(m_q));
      check("cmp_ChangeEvt", 32'(ChangeEvt), 32'(m_evt));
      check("cmp_I_top", 32'(I_top), 32'(ei));
      check("cmp_T_top", 32'(T_top), 32'(et));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge UserCLK);
      #2;
    end
  endtask

  task automatic set_cfg(input int c, input logic [3:0] v);
    ConfigBits[4*c +: 4] = v;
  endtask

  logic [1:0] pv [6] = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
  int         pl [6] = '{5, 2, 6, 7, 1, 8};

  initial begin
    int n;
    int pulses;
    bit found;
    Reset = 1'b0; I = '0; T = '0; O_top = '0;
    // ch0: EDGE_EN=1 SYNC=1 OREG=0; ch1: EDGE_EN=1 OREG=1
    ConfigBits = {4'b1001, 4'b1100};
    #1 Reset = 1'b1;
    #1;
    check("rst_O", 32'(O), 32'h0);
    check("rst_Q", 32'(Q), 32'h0);
    check("rst_evt", 32'(ChangeEvt), 32'h0);
    check("rst_T_top_reg", 32'(T_top[1]), 32'h1);
    check("rst_I_top_reg", 32'(I_top[1]), 32'h0);
    @(posedge UserCLK);
    @(posedge UserCLK);
    #2 Reset = 1'b0;
    chk_en = 1'b1;

    // Debounce latency through the synchroniser
    O_top[0] = 1'b1;
    n = 0; found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(posedge UserCLK); #1;
      if (O[0]) begin found = 1'b1; n = k; end
    end
    check("lat_sync_filter", 32'(n), 32'(LAT_A));
    check("evt_on_change", 32'(ChangeEvt[0]), 32'h1);
    check("q_before", 32'(Q[0]), 32'h0);
    @(posedge UserCLK); #1;
    check("evt_one_cycle", 32'(ChangeEvt[0]), 32'h0);
    check("q_after", 32'(Q[0]), 32'h1);
    #1 O_top[0] = 1'b0;
    tick(10);

    // Bounce rejection, raw input
    set_cfg(0, 4'b1000);
    n = 0;
    for (int e = 1; e <= 12; e++) begin
      O_top[0] = (e == 4) ? 1'b0 : 1'b1;
      @(posedge UserCLK); #1;
      if (O[0] && n == 0) n = e;
      #1;
    end
    check("bounce_rise_edge", 32'(n), 32'(LAT_B));
    O_top[0] = 1'b0;
    tick(10);

    // Output modes
    set_cfg(0, 4'b1010);
    I[0] = 1'b1; T[0] = 1'b0;
    #1;
    check("comb_I_top", 32'(I_top[0]), 32'h1);
    check("comb_T_top", 32'(T_top[0]), 32'h1);
    I[0] = 1'b0; T[0] = 1'b1;
    #1;
    check("comb_I_top_0", 32'(I_top[0]), 32'h0);
    check("comb_T_top_0", 32'(T_top[0]), 32'h0);
    tick(1);
    set_cfg(0, 4'b1011);
    I[0] = 1'b1; T[0] = 1'b0;
    #1;
    check("reg_I_top_old", 32'(I_top[0]), 32'h0);
    check("reg_T_top_old", 32'(T_top[0]), 32'h0);
    tick(1);
    check("reg_I_top_new", 32'(I_top[0]), 32'h1);
    check("reg_T_top_new", 32'(T_top[0]), 32'h1);

    // Reset mid-count
    set_cfg(0, 4'b1001);
    T[0] = 1'b0;
    tick(2);
    check("pre_rst_T_top", 32'(T_top[0]), 32'h0);
    O_top[0] = 1'b1;
    @(posedge UserCLK);
    @(posedge UserCLK);
    #3 Reset = 1'b1;
    #1;
    check("midrst_O", 32'(O[0]), 32'h0);
    check("midrst_T_top", 32'(T_top[0]), 32'h1);
    check("midrst_I_top", 32'(I_top[0]), 32'h0);
    check("midrst_Q", 32'(Q[0]), 32'h0);
    @(posedge UserCLK);
    #3 Reset = 1'b0;
    n = 0; found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(posedge UserCLK); #1;
      if (O[0]) begin found = 1'b1; n = k; end
    end
    check("post_rst_lat", 32'(n), 32'(LAT_D));
    #1 O_top[0] = 1'b0;
    tick(10);

    // EDGE_EN=0 suppresses pulses, and enabling later does not replay them
    set_cfg(0, 4'b0000);
    pulses = 0;
    O_top[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge UserCLK); #1;
      pulses += int'(ChangeEvt[0]);
      #1;
    end
    check("noedge_follow", 32'(O[0]), 32'h1);
    set_cfg(0, 4'b1000);
    for (int k = 0; k < 8; k++) begin
      @(posedge UserCLK); #1;
      pulses += int'(ChangeEvt[0]);
      #1;
    end
    check("noedge_pulses", 32'(pulses), 32'h0);
    O_top[0] = 1'b0;
    tick(10);

    // Both channels in parallel through the synchroniser
    set_cfg(0, 4'b1100);
    set_cfg(1, 4'b1100);
    for (int i = 0; i < 6; i++) begin
      O_top = pv[i];
      I = ~I;
      T = T + 2'b01;
      tick(pl[i]);
    end
    tick(10);
    check("par_final_O", 32'(O), 32'h0);

    // Every-cycle toggle on the raw input
    set_cfg(0, 4'b1000);
    for (int k = 0; k < 8; k++) begin
      O_top[0] = ~O_top[0];
      @(posedge UserCLK); #1;
      check("toggle_follow", 32'(O[0]), DEB ? 32'h0 : 32'(O_top[0]));
      #1;
    end
    O_top[0] = 1'b0;
    tick(10);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_n_bidir_filter.md
IO_N_BIDIR_FILTER -- requirements
Module: io_n_bidir_filter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent bidirectional IO channels, legal range 1..16.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 1..4.
REQ-003 SHALL have parameter FILTER_CNT, default 4: consecutive differing cycles needed to accept an input change, legal range 1..255.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with these ports:
- UserCLK  in  1  fabric user clock; all state is rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- I  in  NUM_CH  fabric-to-pad data.
- T  in  NUM_CH  fabric tristate control; 1 = driver off, before inversion.
- O  out  NUM_CH  filtered pad-to-fabric data.
- Q  out  NUM_CH  O delayed by one cycle.
- ChangeEvt  out  NUM_CH  one-cycle pulse when O changes.
- O_top  in  NUM_CH  pad input.
- I_top  out  NUM_CH  pad output data.
- T_top  out  NUM_CH  pad output enable; 1 = high-Z.
- ConfigBits  in  4*NUM_CH  static configuration, 4 bits per channel.

Function
REQ-005 For channel c, ConfigBits[4c+0..4c+3] SHALL be named OREG, TINV, SYNC and EDGE_EN, in that order.
REQ-006 A SYNC_STAGES-deep flop chain SHALL sample O_top[c] every cycle, whatever the value of SYNC.
REQ-007 The filter input s SHALL be the last chain stage when SYNC=1, and the raw O_top[c] when SYNC=0.
REQ-008 Each channel SHALL hold a filtered register F and a counter cnt of width clog2(FILTER_CNT+1).
REQ-009 When s==F, cnt SHALL load 0 on that cycle.
REQ-010 When s!=F and cnt<FILTER_CNT-1, cnt SHALL increment by 1.
REQ-011 When s!=F and cnt==FILTER_CNT-1, F SHALL load s and cnt SHALL load 0, so a change is accepted after exactly FILTER_CNT consecutive differing cycles.
REQ-012 A bounce (s returning to F before acceptance) SHALL clear cnt, and the next differing cycle SHALL restart counting from 0; cnt SHALL never wrap.
REQ-013 O[c] SHALL equal F combinationally.
REQ-014 Q[c] SHALL equal F registered one further cycle.
REQ-015 ChangeEvt[c] SHALL be registered and pulse high for exactly one cycle, the cycle in which O[c] first shows a new value, only when EDGE_EN=1.
REQ-016 ChangeEvt[c] SHALL stay 0 while EDGE_EN=0, and changes accepted while EDGE_EN=0 SHALL NOT be replayed later.
REQ-017 With OREG=1, I_top[c] SHALL register I[c] and T_top[c] SHALL register T[c] XOR TINV, giving 1-cycle latency.
REQ-018 With OREG=0, I_top[c] and T_top[c] SHALL be combinational from I[c] and T[c] XOR TINV.
REQ-019 Output registers SHALL keep updating while OREG=0, so a switch to OREG=1 presents the value sampled on the previous edge.
REQ-020 ConfigBits changes SHALL take effect on the next rising edge for registered paths and immediately for combinational paths, and SHALL NOT disturb F, cnt or the synchroniser chain.
REQ-021 Channels SHALL be fully independent; simultaneous events on different channels SHALL be handled in parallel.

Reset
REQ-022 While Reset=1, synchroniser stages, F, cnt, Q and ChangeEvt SHALL be 0, the registered I_top SHALL be 0 and the registered T_top SHALL be 1, independent of UserCLK.
REQ-023 Reset asserted mid-filter SHALL discard any partial count; after release, filtering SHALL restart from F=0, cnt=0.
REQ-024 With OREG=0, I_top and T_top SHALL follow their combinational inputs even while Reset=1.

Configuration
REQ-025 Macro IO_DEBOUNCE_EN SHALL control the filter of REQ-008..REQ-012.
REQ-026 With IO_DEBOUNCE_EN defined, the filter SHALL be present exactly as specified in REQ-008..REQ-012.
REQ-027 Without IO_DEBOUNCE_EN, cnt SHALL be absent and F SHALL load s every cycle (1-cycle latency, FILTER_CNT ignored), with all other requirements unchanged.

Verification
REQ-028 Debounce latency: NUM_CH=2, FILTER_CNT=4, SYNC=1, SYNC_STAGES=2; step O_top[0] 0->1 -> O[0] rises exactly 2+4 cycles later, ChangeEvt[0] pulses once in that cycle, Q[0] rises one cycle after O[0].
REQ-029 Bounce rejection: O_top[0] high for 3 cycles, low 1, high 4 with SYNC=0 -> O[0] stays 0 through the first pulse and rises 4 cycles after the second rise begins.
REQ-030 Output modes: I=1, T=0, TINV=1: OREG=0 -> I_top=1 and T_top=1 in the same cycle; OREG=1 -> both change one edge later.
REQ-031 Reset mid-count: Reset pulsed after 2 of 4 differing cycles -> O=0, cnt=0, T_top=1 (OREG=1); after release, 4 more differing cycles are needed.
REQ-032 EDGE_EN=0: any toggle -> ChangeEvt stays 0 while O still follows; then set EDGE_EN=1 with no new change -> no pulse.
REQ-033 Build without IO_DEBOUNCE_EN, SYNC=0: O_top toggles every cycle -> O follows with 1-cycle latency.
